// File: rtl/rb_arb_mux.sv
// Round-robin arbitrated N:1 stream mux with a single registered output stage.
// Latency: 1 cycle from input handshake to out_valid; 1 word/cycle sustained.
// Backpressure: out_ready=0 with a held word freezes the output and drops all in_ready.
//
// Ports:
//   clk, rst         single clock, asynchronous active-high reset
//   in_valid/in_ready per-channel handshake (in_ready is combinational)
//   in_data          flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   mask             1 = channel excluded from arbitration this cycle
//   out_valid/out_ready/out_data/out_chan  registered output stream + source index
module rb_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS-1:0]       mask,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   CH_CNT  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0] req;
  logic                load;
  logic                win_vld;
  logic [SEL_W-1:0]    win_idx;
  logic [SEL_W:0]      cand;
  logic [WIDTH-1:0]    ch_dat [0:CHANNELS-1];

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q,  out_data_d;
  logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
  logic [SEL_W-1:0]    ptr_q,       ptr_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_dat[i] = in_data[i*WIDTH +: WIDTH];
  end

  assign req  = in_valid & ~mask;
  assign load = ~out_valid_q | out_ready;

  // Scan offsets from farthest to nearest so the nearest eligible channel
  // after ptr overwrites any earlier candidate; ptr itself (offset CHANNELS)
  // therefore has the lowest priority. The wrap is a single conditional
  // subtract, which keeps non-power-of-two channel counts in range.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (SEL_W+1)'(k);
      if (cand >= CH_CNT) begin
        cand = cand - CH_CNT;
      end
      if (req[cand[SEL_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[SEL_W-1:0];
      end
    end
  end

  // One-hot grant; rst gates it so nothing is accepted while in reset.
  assign in_ready = (load && win_vld && !rst) ? (CHANNELS'(1) << win_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = win_vld;
      // With no winner the old data/chan are kept; only valid drops.
      if (win_vld) begin
        out_data_d = ch_dat[win_idx];
        out_chan_d = win_idx;
        ptr_d      = win_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_rb_arb_mux.sv
module tb_rb_arb_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: 4 channels x 32 bits
  logic [3:0]   a_vld, a_mask, a_irdy;
  logic [127:0] a_dat;
  logic         a_ovld, a_ordy;
  logic [31:0]  a_odat;
  logic [1:0]   a_ochan;

  // Instance B: 3 channels x 8 bits
  logic [2:0]   b_vld, b_mask, b_irdy;
  logic [23:0]  b_dat;
  logic         b_ovld, b_ordy;
  logic [7:0]   b_odat;
  logic [1:0]   b_ochan;

  rb_arb_mux #(.WIDTH(32), .CHANNELS(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_vld), .in_data(a_dat), .in_ready(a_irdy),
    .mask(a_mask), .out_valid(a_ovld), .out_data(a_odat), .out_chan(a_ochan),
    .out_ready(a_ordy));

  rb_arb_mux #(.WIDTH(8), .CHANNELS(3)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_vld), .in_data(b_dat), .in_ready(b_irdy),
    .mask(b_mask), .out_valid(b_ovld), .out_data(b_odat), .out_chan(b_ochan),
    .out_ready(b_ordy));

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Round-robin rule: first eligible channel after the last grant, modulo c.
  function automatic int rr_pick(input int c, input logic [15:0] elig, input int last);
    int ch;
    for (int d = 1; d <= c; d++) begin
      ch = (last + d) % c;
      if (elig[ch]) return ch;
    end
    return -1;
  endfunction

  // Behavioural model state
  logic        ma_vld, mb_vld;
  logic [31:0] ma_dat;
  logic [7:0]  mb_dat;
  int          ma_chan, mb_chan, ma_last, mb_last;

  always @(posedge clk or posedge rst) begin : model_a
    int w;
    if (rst) begin
      ma_vld = 1'b0; ma_dat = '0; ma_chan = 0; ma_last = 3;
    end else if (!ma_vld || a_ordy) begin
      w = rr_pick(4, 16'(a_vld & ~a_mask), ma_last);
      if (w >= 0) begin
        ma_vld = 1'b1; ma_dat = a_dat[w*32 +: 32]; ma_chan = w; ma_last = w;
      end else begin
        ma_vld = 1'b0;
      end
    end
  end

  always @(posedge clk or posedge rst) begin : model_b
    int w;
    if (rst) begin
      mb_vld = 1'b0; mb_dat = '0; mb_chan = 0; mb_last = 2;
    end else if (!mb_vld || b_ordy) begin
      w = rr_pick(3, 16'(b_vld & ~b_mask), mb_last);
      if (w >= 0) begin
        mb_vld = 1'b1; mb_dat = b_dat[w*8 +: 8]; mb_chan = w; mb_last = w;
      end else begin
        mb_vld = 1'b0;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin : compare
    int wa, wb;
    logic [3:0] ea;
    logic [2:0] eb;
    wa = rr_pick(4, 16'(a_vld & ~a_mask), ma_last);
    ea = (!rst && (!ma_vld || a_ordy) && wa >= 0) ? (4'b0001 << wa) : 4'b0000;
    chk("a_in_ready", 32'(a_irdy), 32'(ea));
    chk("a_out_valid", 32'(a_ovld), 32'(ma_vld));
    chk("a_out_data", a_odat, ma_dat);
    chk("a_out_chan", 32'(a_ochan), 32'(ma_chan));
    wb = rr_pick(3, 16'(b_vld & ~b_mask), mb_last);
    eb = (!rst && (!mb_vld || b_ordy) && wb >= 0) ? (3'b001 << wb) : 3'b000;
    chk("b_in_ready", 32'(b_irdy), 32'(eb));
    chk("b_out_valid", 32'(b_ovld), 32'(mb_vld));
    chk("b_out_data", 32'(b_odat), 32'(mb_dat));
    chk("b_out_chan", 32'(b_ochan), 32'(mb_chan));
    chk("b_chan_range", 32'(b_ochan < 2'd3), 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_seq[6] = '{0, 1, 2, 3, 0, 1};
  int mk_seq[6] = '{1, 2, 3, 1, 2, 3};
  int b_seq[6]  = '{0, 1, 2, 0, 1, 2};

  initial begin
    rst = 1'b1;
    a_vld = '0; a_dat = '0; a_mask = '0; a_ordy = 1'b0;
    b_vld = '0; b_dat = '0; b_mask = '0; b_ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_ovld), 32'd0);
    chk("rst_out_data", a_odat, 32'd0);
    chk("rst_out_chan", 32'(a_ochan), 32'd0);
    a_vld = 4'b0100;
    #1;
    chk("rst_in_ready_forced", 32'(a_irdy), 32'd0);

    // Single channel
    rst = 1'b0;
    a_dat[2*32 +: 32] = 32'hA5A5_0002;
    a_ordy = 1'b1;
    #1;
    chk("single_in_ready", 32'(a_irdy), 32'b0100);
    step();
    chk("single_valid", 32'(a_ovld), 32'd1);
    chk("single_data", a_odat, 32'hA5A5_0002);
    chk("single_chan", 32'(a_ochan), 32'd2);

    // Load with no winner: valid drops, data/chan hold
    a_vld = 4'b0000;
    step();
    chk("nowin_valid", 32'(a_ovld), 32'd0);
    chk("nowin_data_hold", a_odat, 32'hA5A5_0002);
    chk("nowin_chan_hold", 32'(a_ochan), 32'd2);

    // Reset mid-operation
    a_vld = 4'b0010;
    a_dat[1*32 +: 32] = 32'h1234_5678;
    a_ordy = 1'b0;
    step();
    chk("pre_rst_data", a_odat, 32'h1234_5678);
    chk("pre_rst_chan", 32'(a_ochan), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(a_ovld), 32'd0);
    chk("async_rst_data", a_odat, 32'd0);
    chk("async_rst_chan", 32'(a_ochan), 32'd0);
    a_vld = 4'b1111;
    for (int i = 0; i < 4; i++) a_dat[i*32 +: 32] = 32'h100 + 32'(i);
    a_ordy = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("post_rst_first_grant", 32'(a_irdy), 32'b0001);

    // Round robin, no bubbles
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_valid", 32'(a_ovld), 32'd1);
      chk("rr_chan", 32'(a_ochan), 32'(rr_seq[k]));
      chk("rr_data", a_odat, 32'h100 + 32'(rr_seq[k]));
    end

    // Backpressure while holding channel 1
    a_ordy = 1'b0;
    #1;
    chk("bp_in_ready", 32'(a_irdy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_chan", 32'(a_ochan), 32'd1);
      chk("bp_data", a_odat, 32'h101);
      chk("bp_in_ready_hold", 32'(a_irdy), 32'd0);
    end
    a_ordy = 1'b1;
    #1;
    chk("bp_release_ready", 32'(a_irdy), 32'b0100);
    step();
    chk("bp_next_chan", 32'(a_ochan), 32'd2);
    chk("bp_next_data", a_odat, 32'h102);

    // Mask channel 0
    step();
    chk("pre_mask_chan", 32'(a_ochan), 32'd3);
    a_mask = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("mask_ch0_ready", 32'(a_irdy[0]), 32'd0);
      step();
      chk("mask_chan", 32'(a_ochan), 32'(mk_seq[k]));
    end
    a_mask = 4'b0000;
    #1;
    chk("unmask_ready", 32'(a_irdy), 32'b0001);
    step();
    chk("unmask_chan", 32'(a_ochan), 32'd0);
    chk("unmask_data", a_odat, 32'h100);
    a_vld = 4'b0000;
    step();

    // Three-channel instance
    b_vld = 3'b111;
    b_dat = {8'h12, 8'h11, 8'h10};
    b_ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("b_rr_chan", 32'(b_ochan), 32'(b_seq[k]));
      chk("b_rr_data", 32'(b_odat), 32'h10 + 32'(b_seq[k]));
    end
    b_vld = 3'b100;
    step();
    chk("b_self_regrant_chan", 32'(b_ochan), 32'd2);
    chk("b_self_regrant_valid", 32'(b_ovld), 32'd1);
    b_vld = 3'b000;
    repeat (2) step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/rb_arb_mux.md
Name: rb_arb_mux

Overview:
- Parametrised successor to the fixed 2/4/8-way combinational muxes.
- Selects among CHANNELS valid/ready input streams using a round-robin arbiter and a per-channel mask.
- Registers the winning word in a single output stage with backpressure.
- Used wherever several core-side producers share one consumer (e.g. memory request path, writeback port).

Parameters:
- WIDTH, 32, data width of every channel and of the output.
- CHANNELS, 4, number of input channels; legal range 2..16, need not be a power of two.
- SEL_W (localparam), max(1, $clog2(CHANNELS)), width of the channel index.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel request; bit i belongs to channel i.
- in_data  input  CHANNELS*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel accept; combinational.
- mask  input  CHANNELS  1 = channel i is excluded from arbitration.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset: clk is single clock; rst is asynchronous, active-high. While rst=1:
  - out_valid=0, out_data=0, out_chan=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority after reset.
  - in_ready is forced to 0.
  - Reset asserted mid-transfer discards the held word immediately; nothing is replayed.
- Eligible set: req = in_valid & ~mask.
- Load enable: load = ~out_valid | out_ready.
- Arbitration (combinational):
  - Winner g is the first set bit of req, searching ptr+1, ptr+2, ... modulo CHANNELS.
  - ptr itself is searched last.
  - No winner when req == 0.
- in_ready[i] = load & (req != 0) & (g == i). At most one bit is set; masked channels never see ready.
- Transfer on channel g when in_valid[g] & in_ready[g]. At the clock edge:
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1, ptr <= g.
- Load with no winner: out_valid <= 0; out_data and out_chan hold their last values; ptr unchanged.
- Hold: out_valid=1 & out_ready=0 leaves out_data, out_chan and ptr unchanged, and all in_ready=0.
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Simultaneous drain and fill: output accepted (out_ready=1) in the same cycle a new winner exists. The new word loads with no bubble and out_valid stays 1.
- Pointer wrap: index arithmetic is modulo CHANNELS, including non-power-of-two values. out_chan never exceeds CHANNELS-1.
- Mask changes:
  - Take effect in the same cycle's arbitration.
  - Never alter a word already in the output register.
- Fairness: with all channels continuously eligible, each is granted once every CHANNELS transfers.
- Upstream rule: in_data must stay stable while in_valid is high and unaccepted. The block does not check this.
- No combinational path from out_ready to out_data/out_valid. A combinational path from out_ready to in_ready is permitted.

Test Plan:
1. Reset mid-operation:
   - Stimulus: rst pulsed asynchronously (between edges) while out_valid=1, out_data=0x1234_5678.
   - Response: out_valid=0, out_data=0, out_chan=0 immediately. After release, with all four channels valid, first grant is channel 0.
2. Single channel:
   - Stimulus: in_valid=4'b0100, channel 2 data 0xA5A5_0002, out_ready=1.
   - Response: in_ready=4'b0100 the same cycle. Next cycle out_valid=1, out_data=0xA5A5_0002, out_chan=2.
3. Round robin:
   - Stimulus: all four channels held valid (data = 0x100+i), out_ready=1.
   - Response: out_chan sequence 0,1,2,3,0,1 with matching data and no bubbles.
4. Backpressure:
   - Stimulus: out_ready=0 for 3 cycles while out_valid=1, out_chan=1.
   - Response: out_data and out_chan are stable and in_ready=0 throughout. After out_ready=1, next grant is channel 2.
5. Mask:
   - Stimulus: mask=4'b0001, all channels valid, out_ready=1.
   - Response: out_chan sequence 1,2,3,1,2. Channel 0 never sees in_ready. Clearing mask when ptr=3 yields channel 0 next.
6. CHANNELS=3, WIDTH=8:
   - Stimulus: all channels valid.
   - Response: out_chan sequence 0,1,2,0 and out_chan is never 3. With only channel 2 valid and ptr=2, channel 2 wins again.
